// File: rtl/uart_cmd_arbiter_pkg.sv
// uart_pkg: shared definitions for the UART command arbiter.
//   - Command packet field positions (R/W, address, data).
//   - R/W bit encodings.
//   - Arbiter FSM state type.
package uart_pkg;

    localparam int CMD_RW_BIT   = 15;
    localparam int CMD_ADDR_MSB = 14;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_MSB = 7;
    localparam int CMD_DATA_LSB = 0;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD
    } arb_state_t;

endpackage

// File: rtl/uart_cmd_arbiter_if.sv
// uart_cmd_arbiter_if: requester and UART-side handshake bundle.
//   Requester side : req_valid, req_cmd, req_ready, rsp_valid, rsp_data, rsp_err
//   UART side      : uart_cmd, uart_valid, uart_ready, uart_read_data, uart_read_valid
//   master modport : the arbiter's view
//   slave modport  : the view of the surrounding requesters / UART interface
interface uart_cmd_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_PKT_LEN = 16
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*CMD_PKT_LEN-1:0] req_cmd;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_WIDTH-1:0]          rsp_data;
    logic                           rsp_err;
    logic [CMD_PKT_LEN-1:0]         uart_cmd;
    logic                           uart_valid;
    logic                           uart_ready;
    logic [DATA_WIDTH-1:0]          uart_read_data;
    logic                           uart_read_valid;

    modport master (
        input  req_valid, req_cmd, uart_ready, uart_read_data, uart_read_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err, uart_cmd, uart_valid
    );

    modport slave (
        output req_valid, req_cmd, uart_ready, uart_read_data, uart_read_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, uart_cmd, uart_valid
    );

endinterface

// File: rtl/uart_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_valid  : per-requester request
//   last_grant : index of the most recent grant; search starts just after it
//   grant      : one-hot winner (all zero when nobody requests)
//   grant_idx  : encoded winner index
//   grant_any  : at least one requester is valid
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        // Offsets 1..NUM_REQ visit every requester once, ending on last_grant itself.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((i + 32'(last_grant)) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: shares one UART interface command port between NUM_REQ
// requesters with round-robin priority; one command in flight at a time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_cmd_arbiter_if.master
//              requester side: req_valid/req_cmd/req_ready, rsp_valid/rsp_data/rsp_err
//              UART side     : uart_cmd/uart_valid/uart_ready, uart_read_data/uart_read_valid
module uart_cmd_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_PKT_LEN = 16,
    parameter int RD_TIMEOUT  = 50_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_TIMEOUT);

    arb_state_t             state;
    logic [CMD_PKT_LEN-1:0] cmd_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       last_grant;
    logic [CNT_W-1:0]       tmo_cnt;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [CMD_PKT_LEN-1:0] pick_cmd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant),
        .grant      (pick_oh),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    always_comb begin
        pick_cmd = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_cmd = bus.req_cmd[i*CMD_PKT_LEN +: CMD_PKT_LEN];
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE && !rst) ? pick_oh : '0;
    // The latched command is what the UART sees, so uart_cmd is registered by construction.
    assign bus.uart_cmd  = cmd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cmd_q          <= '0;
            grant_q        <= '0;
            last_grant     <= IDX_W'(NUM_REQ - 1);
            tmo_cnt        <= '0;
            bus.uart_valid <= 1'b0;
            bus.rsp_valid  <= '0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        cmd_q          <= pick_cmd;
                        grant_q        <= pick_idx;
                        last_grant     <= pick_idx;
                        bus.uart_valid <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.uart_ready) begin
                        bus.uart_valid <= 1'b0;
                        if (cmd_q[CMD_RW_BIT] == CMD_WR) begin
                            state <= ST_IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    // Data is checked first so it wins over a same-cycle expiry.
                    if (bus.uart_read_valid) begin
                        bus.rsp_valid[grant_q] <= 1'b1;
                        bus.rsp_data           <= bus.uart_read_data;
                        bus.rsp_err            <= 1'b0;
                        state                  <= ST_IDLE;
                    end else if (tmo_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        bus.rsp_valid[grant_q] <= 1'b1;
                        bus.rsp_data           <= '0;
                        bus.rsp_err            <= 1'b1;
                        state                  <= ST_IDLE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
